// File: rtl/cabs_sched_pkg.sv
// Shared definitions for the complex-magnitude scheduler and its datapath.
package cabs_sched_pkg;

  // Datapath latency shared with the magnitude pipeline so the two cannot drift.
  localparam int CABS_LATENCY = 8;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/cabs_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first request after ptr wins.
module rr_arbiter
  import cabs_sched_pkg::*;
#(
  parameter int NUM_REQ = 20,
  parameter int PTR_W   = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic found_s;
  logic hit_s;

  // Walk offsets ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); the first requester seen wins.
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        hit_s    = req[j] & ~found_s & (((int'(ptr) + k + 1) % NUM_REQ) == j);
        grant[j] = grant[j] | hit_s;
        found_s  = found_s | hit_s;
      end
    end
  end

endmodule

// File: rtl/cabs_sched.sv
// Packet-locking, credit-gated round-robin scheduler in front of the shared
// magnitude datapath, with a tag shadow pipeline matched to the datapath latency.
module cabs_sched
  import cabs_sched_pkg::*;
#(
  parameter int NUM_TAGS   = 20,
  parameter int DATA_WIDTH = 256,
  parameter int LATENCY    = CABS_LATENCY,
  parameter int CREDITS    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_TAGS-1:0]            s_axis_tvalid,
  output logic [NUM_TAGS-1:0]            s_axis_tready,
  input  logic [NUM_TAGS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_TAGS-1:0]            s_axis_tlast,
  output logic                           dp_valid,
  output logic [DATA_WIDTH-1:0]          dp_data,
  output logic [NUM_TAGS-1:0]            dp_chan,
  output logic                           dp_valid_d,
  output logic [NUM_TAGS-1:0]            dp_chan_d,
  input  logic                           credit_return,
  output logic                           credit_ovf
);

  localparam int PTR_W = (NUM_TAGS > 1) ? clog2(NUM_TAGS) : 1;
  localparam int CNT_W = clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CREDITS);
  localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(NUM_TAGS - 1);

  logic [PTR_W-1:0]      ptr_r;
  logic                  lock_r;
  logic [PTR_W-1:0]      lock_tag_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  credit_ovf_r;
  logic [NUM_TAGS:0]     shadow_r [LATENCY];

  logic [NUM_TAGS-1:0]   arb_grant_s;
  logic [NUM_TAGS-1:0]   lock_mask_s;
  logic [NUM_TAGS-1:0]   cand_s;
  logic [NUM_TAGS-1:0]   grant_s;
  logic                  eligible_s;
  logic                  xfer_s;
  logic [PTR_W-1:0]      sel_idx_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  sel_last_s;

  rr_arbiter #(
    .NUM_REQ (NUM_TAGS),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req   (s_axis_tvalid),
    .ptr   (ptr_r),
    .grant (arb_grant_s)
  );

  assign eligible_s    = (cnt_r != '0);
  assign xfer_s        = |grant_s;
  assign s_axis_tready = grant_s;
  assign credit_ovf    = credit_ovf_r;
  assign dp_valid_d    = shadow_r[LATENCY-1][NUM_TAGS];
  assign dp_chan_d     = shadow_r[LATENCY-1][NUM_TAGS-1:0];

  // One-hot view of the locked tag.
  always_comb begin
    lock_mask_s = '0;
    for (int j = 0; j < NUM_TAGS; j++) begin
      lock_mask_s[j] = (PTR_W'(j) == lock_tag_r);
    end
  end

  // Candidate is the locked tag mid-packet, else the round-robin winner; gated by credits and reset.
  always_comb begin
    if (lock_r) begin
      cand_s = s_axis_tvalid & lock_mask_s;
    end else begin
      cand_s = arb_grant_s;
    end
    if (!rst && eligible_s) begin
      grant_s = cand_s;
    end else begin
      grant_s = '0;
    end
  end

  // Encode the granted tag into index, beat and last flag (grant is one-hot or zero).
  always_comb begin
    sel_idx_s  = '0;
    sel_data_s = '0;
    sel_last_s = 1'b0;
    for (int j = 0; j < NUM_TAGS; j++) begin
      sel_idx_s  = sel_idx_s | (grant_s[j] ? PTR_W'(j) : '0);
      sel_data_s = sel_data_s |
                   (s_axis_tdata[j*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_s[j]}});
      sel_last_s = sel_last_s | (grant_s[j] & s_axis_tlast[j]);
    end
  end

  // Round-robin pointer and packet lock advance on every transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r      <= PTR_INIT;
      lock_r     <= 1'b0;
      lock_tag_r <= '0;
    end else if (xfer_s) begin
      ptr_r      <= sel_idx_s;
      lock_r     <= ~sel_last_s;
      lock_tag_r <= sel_idx_s;
    end else begin
      ptr_r      <= ptr_r;
      lock_r     <= lock_r;
      lock_tag_r <= lock_tag_r;
    end
  end

  // Downstream credit counter; a return with nothing outstanding is flagged and sticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= CNT_FULL;
      credit_ovf_r <= 1'b0;
    end else begin
      case ({xfer_s, credit_return})
        2'b10: begin
          cnt_r <= cnt_r - CNT_W'(1);
        end
        2'b01: begin
          if (cnt_r == CNT_FULL) begin
            credit_ovf_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Register the issued beat toward the datapath; channel is zero on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_valid <= 1'b0;
      dp_chan  <= '0;
      dp_data  <= '0;
    end else begin
      dp_valid <= xfer_s;
      dp_chan  <= grant_s;
      if (xfer_s) begin
        dp_data <= sel_data_s;
      end else begin
        dp_data <= dp_data;
      end
    end
  end

  // Free-running tag shadow pipeline that keeps pace with the datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        shadow_r[i] <= '0;
      end
    end else begin
      shadow_r[0] <= {dp_valid, dp_chan};
      for (int i = 1; i < LATENCY; i++) begin
        shadow_r[i] <= shadow_r[i-1];
      end
    end
  end

endmodule
